// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters.
// Grants and mux selects are registered. y is a purely combinational mux
// steered by the registered select. A burst limit forces a handoff when
// another requester is waiting.
module rr_mux_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       gnt,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             busy
);

    localparam int unsigned   CntW   = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);
    localparam logic [CntW-1:0] OneCnt = CntW'(1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [3:0]      gnt_q,   gnt_d;
    logic [1:0]      sel_q,   sel_d;
    logic [1:0]      last_q,  last_d;
    logic [CntW-1:0] cnt_q,   cnt_d;

    logic [3:0] others;
    logic [2:0] pick_all;
    logic [2:0] pick_oth;

    // Returns {found, index} of the first set bit at or after ptr+1, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Next-state: pick winners and apply the keep / handoff / release rules.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        // Everyone requesting except the current holder.
        others   = req & ~gnt_q;
        pick_all = rr_pick(req, last_q);
        pick_oth = rr_pick(others, last_q);

        case (state_q)
            StIdle: begin
                if (pick_all[2]) begin
                    state_d = StGrant;
                    gnt_d   = 4'b0001 << pick_all[1:0];
                    sel_d   = pick_all[1:0];
                    last_d  = pick_all[1:0];
                    cnt_d   = OneCnt;
                end
            end
            StGrant: begin
                if (req[sel_q] && ((cnt_q < MaxCnt) || (others == 4'b0000))) begin
                    // Keep the grant; the counter saturates at the limit.
                    if (cnt_q != MaxCnt) begin
                        cnt_d = cnt_q + OneCnt;
                    end
                end else if (pick_oth[2]) begin
                    // Burst expiry or early release: hand off with no idle bubble.
                    gnt_d  = 4'b0001 << pick_oth[1:0];
                    sel_d  = pick_oth[1:0];
                    last_d = pick_oth[1:0];
                    cnt_d  = OneCnt;
                end else begin
                    // Nobody left; the select keeps its last value.
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data mux steered by the registered select; no storage on the data path.
    always_comb begin
        y = i0;
        case (sel_q)
            2'd0:    y = i0;
            2'd1:    y = i1;
            2'd2:    y = i2;
            2'd3:    y = i3;
            default: y = i0;
        endcase
    end

    assign gnt     = gnt_q;
    assign s1      = sel_q[1];
    assign s0      = sel_q[0];
    assign y_valid = |gnt_q;
    assign busy    = (state_q == StGrant);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: two arbiters (MAX_BURST 4 and 1) share stimulus and are
// compared every cycle against a behavioural round-robin model, plus
// directed sequences with hand-computed expectations.
module tb_rr_mux_arbiter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] din [4];

    logic [3:0]   gnt_w  [2];
    logic         s1_w   [2];
    logic         s0_w   [2];
    logic [W-1:0] y_w    [2];
    logic         yv_w   [2];
    logic         busy_w [2];

    int checks = 0;
    int errors = 0;

    // Model state per instance: current holder (-1 = idle), last winner,
    // burst count, and the select value currently shown.
    int mb     [2] = '{4, 1};
    int m_cur  [2] = '{-1, -1};
    int m_last [2] = '{3, 3};
    int m_cnt  [2] = '{0, 0};
    int m_sel  [2] = '{0, 0};

    rr_mux_arbiter #(.WIDTH(W), .MAX_BURST(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .gnt(gnt_w[0]), .s1(s1_w[0]), .s0(s0_w[0]), .y(y_w[0]),
        .y_valid(yv_w[0]), .busy(busy_w[0])
    );

    rr_mux_arbiter #(.WIDTH(W), .MAX_BURST(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .gnt(gnt_w[1]), .s1(s1_w[1]), .s0(s0_w[1]), .y(y_w[1]),
        .y_valid(yv_w[1]), .busy(busy_w[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Behavioural model: updated on each rising edge, reset asynchronously.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int m = 0; m < 2; m++) begin
                if (!rst_n) begin
                    m_cur[m]  = -1;
                    m_last[m] = 3;
                    m_cnt[m]  = 0;
                    m_sel[m]  = 0;
                end else if (m_cur[m] < 0) begin
                    if (req != 4'b0000) begin
                        m_cur[m]  = pick(req, m_last[m]);
                        m_last[m] = m_cur[m];
                        m_sel[m]  = m_cur[m];
                        m_cnt[m]  = 1;
                    end
                end else begin
                    logic [3:0] oth;
                    oth = req & ~(4'b0001 << m_cur[m]);
                    if (req[m_cur[m]] && (m_cnt[m] < mb[m] || oth == 4'b0000)) begin
                        if (m_cnt[m] < mb[m]) m_cnt[m] = m_cnt[m] + 1;
                    end else if (oth != 4'b0000) begin
                        m_cur[m]  = pick(oth, m_last[m]);
                        m_last[m] = m_cur[m];
                        m_sel[m]  = m_cur[m];
                        m_cnt[m]  = 1;
                    end else begin
                        m_cur[m] = -1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                int eg;
                eg = (m_cur[m] < 0) ? 0 : (1 << m_cur[m]);
                check($sformatf("model_gnt[%0d]", m), 32'(gnt_w[m]), 32'(eg));
                check($sformatf("model_sel[%0d]", m), 32'({s1_w[m], s0_w[m]}), 32'(m_sel[m]));
                check($sformatf("model_yv[%0d]", m), 32'(yv_w[m]), 32'(m_cur[m] >= 0));
                check($sformatf("model_busy[%0d]", m), 32'(busy_w[m]), 32'(m_cur[m] >= 0));
                if (m_cur[m] >= 0) begin
                    check($sformatf("model_y[%0d]", m), 32'(y_w[m]), 32'(din[m_cur[m]]));
                end
            end
        end
    end

    // Drive inputs just after a falling edge, return on the next falling edge.
    task automatic tick(input logic [3:0] r);
        #1;
        req = r;
        for (int k = 0; k < 4; k++) din[k] = W'($urandom);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [3:0] exp_a [9];
    logic [3:0] exp_b [9];
    logic [3:0] r;

    initial begin
        for (int k = 0; k < 4; k++) din[k] = '0;
        @(negedge clk);
        do_reset();
        check("rst_gnt", 32'(gnt_w[0]), 32'h0);
        check("rst_sel", 32'({s1_w[0], s0_w[0]}), 32'h0);
        check("rst_yv", 32'(yv_w[0]), 32'h0);
        check("rst_busy", 32'(busy_w[0]), 32'h0);

        // Burst limit with two contenders.
        exp_a = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1};
        exp_b = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1};
        for (int c = 0; c < 9; c++) begin
            tick(4'b0011);
            check("burst_a", 32'(gnt_w[0]), 32'(exp_a[c]));
            check("burst_b", 32'(gnt_w[1]), 32'(exp_b[c]));
        end

        // Full contention rotation.
        do_reset();
        exp_a = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_b = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int c = 0; c < 5; c++) begin
            tick(4'b1111);
            check("rot_a", 32'(gnt_w[0]), 32'(exp_a[c]));
            check("rot_b", 32'(gnt_w[1]), 32'(exp_b[c]));
            check("rot_sel_b", 32'({s1_w[1], s0_w[1]}), 32'(c % 4));
            check("rot_y_b", 32'(y_w[1]), 32'(din[c % 4]));
        end

        // Single requester never forced off.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(4'b0010);
            check("single_gnt", 32'(gnt_w[0]), 32'h2);
            check("single_sel", 32'({s1_w[0], s0_w[0]}), 32'h1);
            check("single_y", 32'(y_w[0]), 32'(din[1]));
        end
        tick(4'b0000);
        check("single_drop", 32'(gnt_w[0]), 32'h0);
        check("single_hold_sel", 32'({s1_w[0], s0_w[0]}), 32'h1);

        // Wrap-around priority: last=2 then 1001 from idle picks source 3.
        tick(4'b0100);
        check("wrap_setup", 32'(gnt_w[0]), 32'h4);
        tick(4'b0000);
        tick(4'b1001);
        check("wrap_gnt", 32'(gnt_w[0]), 32'h8);
        check("wrap_sel", 32'({s1_w[0], s0_w[0]}), 32'h3);

        // Early release handoff and burst count restart.
        tick(4'b1000);
        tick(4'b0010);
        check("handoff_gnt", 32'(gnt_w[0]), 32'h2);
        exp_a = '{4'h2, 4'h2, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int c = 0; c < 4; c++) begin
            tick(4'b1010);
            check("handoff_cnt", 32'(gnt_w[0]), 32'(exp_a[c]));
        end

        // Asynchronous reset mid-grant.
        #1;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check("async_gnt", 32'(gnt_w[m]), 32'h0);
            check("async_sel", 32'({s1_w[m], s0_w[m]}), 32'h0);
            check("async_yv", 32'(yv_w[m]), 32'h0);
            check("async_busy", 32'(busy_w[m]), 32'h0);
        end
        #1;
        req   = 4'b0100;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt_w[0]), 32'h4);
        check("post_rst_y", 32'(y_w[0]), 32'(din[2]));
        check("post_rst_busy", 32'(busy_w[0]), 32'h1);

        // Randomized traffic with sticky request patterns and rare resets.
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                tick(r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux between four requesters.
- Arbitrates four request lines and drives the mux selects s1/s0 from registered state.
- Presents the selected input on y, with y_valid marking cycles that carry a granted source.
- Enforces a maximum burst length so that no requester can starve the others.

Parameters:
- WIDTH, 8, data width of i0..i3 and y (must be >= 1).
- MAX_BURST, 4, maximum consecutive grant cycles while another requester is waiting (must be >= 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per source; req[k] pairs with input ik.
- i0  input  WIDTH  source 0 data.
- i1  input  WIDTH  source 1 data.
- i2  input  WIDTH  source 2 data.
- i3  input  WIDTH  source 3 data.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- s1  output  1  mux select MSB, registered.
- s0  output  1  mux select LSB, registered.
- y  output  WIDTH  combinational mux of i0..i3 by {s1,s0}: 00->i0, 01->i1, 10->i2, 11->i3.
- y_valid  output  1  equals |gnt.
- busy  output  1  high while the state is GRANT.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, gnt=0000, {s1,s0}=00, y_valid=0, busy=0.
  - last pointer=3, so source 0 has highest priority after reset.
  - Burst count=0.
  - Reset asserted mid-grant clears all of this immediately, without waiting for a clock edge.
- Round-robin pick:
  - Search starts at (last+1) mod 4 and wraps; the first set req bit wins.
  - On every new grant, last takes the winner's index.
- IDLE:
  - If req==0000, stay in IDLE; {s1,s0} holds its previous value.
  - If any req is set at an edge, the pick is made from that edge's req.
  - At that edge, gnt, {s1,s0} and last update, count=1, and the state moves to GRANT.
  - Latency is one cycle from req sampled to gnt visible.
- GRANT, holding source g (each clock edge):
  - a) req[g]=1 and (count<MAX_BURST or no other req set): keep the grant; count increments and saturates at MAX_BURST.
  - b) req[g]=1, count==MAX_BURST and another req is set: switch to the round-robin winner among the other requesters; count=1. There is no idle bubble.
  - c) req[g]=0 and another req is set: switch directly to the round-robin winner; count=1.
  - d) req[g]=0 and no req set: gnt=0000 and the state returns to IDLE; {s1,s0} hold.
- Widths and arithmetic:
  - Counter width is clog2(MAX_BURST+1).
  - With MAX_BURST=1, competing requesters alternate every cycle.
- Grant integrity:
  - gnt is always one-hot or zero.
  - {s1,s0} always encodes the index of the set gnt bit whenever gnt is nonzero.
- Simultaneous events:
  - All four requesters asserting together are served 0,1,2,3,0... from reset.
  - A requester dropping in the same edge as the burst expiry follows rule c.
- Data path:
  - The data path has no storage; y follows i-inputs combinationally under the registered select.
  - y is don't-care when y_valid=0.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-grant, asynchronously between clock edges.
  - Required: gnt=0000, {s1,s0}=00, y_valid=0 and busy=0 immediately; after release with req=0100, gnt=0100 one edge later and y=i2.
- Single requester:
  - Stimulus: req=0010 for 10 cycles with MAX_BURST=4, then req=0000.
  - Required: gnt=0010 for all 10 cycles (no forced switch without contention); y=i1, {s1,s0}=01; gnt=0000 one edge after the drop.
- Burst limit:
  - Stimulus: req=0011 held constant from reset, MAX_BURST=4.
  - Required: gnt=0001 for exactly 4 cycles, then 0010 for 4 cycles, then 0001, with no zero-grant cycles between.
- Full contention rotation:
  - Stimulus: req=1111, MAX_BURST=1.
  - Required: gnt sequence 0001,0010,0100,1000,0001; {s1,s0} sequence 00,01,10,11,00; y matches each input.
- Early release handoff:
  - Stimulus: grant on source 3, then req[3] drops while req[1] is high.
  - Required: gnt goes 1000 -> 0010 on the next edge and count restarts at 1.
- Wrap-around priority:
  - Stimulus: last=2; req=1001 applied from IDLE.
  - Required: source 3 wins; gnt=1000, {s1,s0}=11.
